imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
// - Serial program loader upstream of riscv_pipelined_core. Replaces $readmemh preload for hardware/system sims.
// - Accepts a byte stream (valid/ready): 4-byte LE word count, N LE 32-bit words, 1 XOR checksum byte.
// - Writes the words into mem_ctrl instruction memory from word 0 upward.
// - Holds the core in reset until a clean, checksum-verified load completes.
// PARAMETERS
// - IMEM_DEPTH      1024  instruction memory depth in 32-bit words; maximum legal word count
// - ADDR_W          $clog2(IMEM_DEPTH)  word-address width
// - TIMEOUT_CYCLES  4096  maximum idle cycles between accepted bytes while busy
// PORTS
// - clk           in   1         clock
// - reset         in   1         asynchronous, active-high reset
// - start         in   1         single-cycle pulse that arms a load
// - rx_valid      in   1         byte available
// - rx_data       in   8         byte value
// - rx_ready      out  1         loader accepts a byte (transfer = rx_valid & rx_ready)
// - imem_we       out  1         one-cycle instruction memory write strobe
// - imem_addr     out  ADDR_W    word address
// - imem_wdata    out  32        instruction word
// - core_hold     out  1         1 = keep core in reset
// - busy          out  1         load in progress
// - done          out  1         sticky: load succeeded
// - err           out  1         sticky: load failed
// - err_code      out  2         0 none, 1 bad length, 2 checksum mismatch, 3 timeout
// - words_loaded  out  ADDR_W+1  count of words written this load
// BEHAVIOUR
// - Reset (async): state IDLE. All outputs 0 except core_hold=1.
// - FSM states: IDLE, LEN, DATA, CSUM, DONE, ERR. All outputs are registered.
// - rx_ready=1 only in LEN, DATA and CSUM. busy=1 in those same states.
// - IDLE/DONE/ERR + start: next cycle enter LEN. On entry clear done, err, err_code, words_loaded, checksum, byte counters; set core_hold=1.
// - start while busy: ignored.
// - LEN: capture 4 bytes LE into len[31:0].
//   - After the 4th byte, len==0 or len>IMEM_DEPTH -> ERR, err_code=1.
//   - Otherwise go to DATA.
// - DATA: bytes are packed LE; byte 0 lands in [7:0].
//   - In the cycle after the 4th byte of a word is accepted: imem_we=1, imem_addr=word index, imem_wdata=word.
//   - Then word index and words_loaded increment.
//   - After word len-1 is written, go to CSUM. No write backpressure.
// - Checksum: XOR of all DATA bytes; length bytes are excluded.
//   - CSUM accepts 1 byte. Match -> DONE, mismatch -> ERR with err_code=2.
// - Timeout: idle counter runs while busy, clears on each accepted byte.
//   - Reaching TIMEOUT_CYCLES -> ERR, err_code=3.
//   - A partial word is discarded; it is never written.
// - Byte accept and timeout expiry in the same cycle: the byte wins and the counter clears.
// - DONE: core_hold=0, done=1 until the next start or reset.
// - ERR: core_hold=1, err=1. Words already written stay in imem; no rollback.
// - Reset mid-load: immediate return to reset values. A partially written imem is not cleared.
// - words_loaded never exceeds IMEM_DEPTH. imem_addr never wraps.
// STRUCTURE
// - riscv_pkg additions:
//   - loader_state_t enum (IDLE..ERR)
//   - loader_err_t enum (LDR_ERR_NONE/LEN/CSUM/TIMEOUT)
//   - LDR_LEN_BYTES=4 constant
// - One sub-module: byte_word_packer.
//   - Byte shift/count register with clr, push, byte in.
//   - Outputs word_valid pulse and word[31:0].
//   - Reused for the LEN field and for DATA words.
// - FSM, checksum, timeout and write-port logic live in imem_boot_loader.
// TESTING (IMEM_DEPTH=8, TIMEOUT_CYCLES=16 unless stated)
// - 1. start; len=3; words 0x00500293, 0x01400313, 0x00628393; correct csum
//   -> imem_we pulses at addr 0,1,2 with those exact data; done=1, core_hold=0, words_loaded=3.
// - 2. len=0, then len=9 (separate loads)
//   -> err=1, err_code=1 each time; no imem_we; core_hold=1. len=8 -> last write at addr 7, done=1.
// - 3. Case 1 with csum^0x01
//   -> err_code=2; three writes occurred; core_hold=1, done=0.
// - 4. rx_valid gap of 15 cycles mid-word -> load succeeds.
//   - Gap of 16 cycles -> err_code=3; the partial word is never written.
// - 5. reset asserted after the 2nd data word is written
//   -> next edge: busy=0, core_hold=1, words_loaded=0.
//   - Then a fresh start with case 1 -> done=1.
// - 6. start pulse during DATA -> ignored. start in DONE -> core_hold=1 next cycle, state LEN.
//   - Random rx_valid throttling on case 1 -> identical writes.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the serial instruction-memory boot loader.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

  typedef enum logic [1:0] {
    LDR_ERR_NONE    = 2'd0,
    LDR_ERR_LEN     = 2'd1,
    LDR_ERR_CSUM    = 2'd2,
    LDR_ERR_TIMEOUT = 2'd3
  } loader_err_t;

  // Bytes per 32-bit field, used for both the length header and data words.
  localparam int LDR_LEN_BYTES = 4;

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Little-endian byte-to-word packer. The completed word is presented
// combinationally alongside the 4th push so the caller can act in that cycle.
module byte_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  // Shift bytes in from the top so byte 0 ends up in the low lane.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_push) begin
      r_shift <= {i_byte, r_shift[23:8]};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign o_word       = {i_byte, r_shift};
  assign o_word_valid = i_push & (r_cnt == 2'(LDR_LEN_BYTES - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Serial instruction-memory boot loader: length header, LE data words,
// XOR checksum byte. Holds the core in reset until a verified load completes.
//
// state | meaning
// IDLE  | after reset, waiting for start; core held
// LEN   | collecting the 4-byte word count
// DATA  | collecting data words, one imem write per completed word
// CSUM  | waiting for the checksum byte
// DONE  | load verified, core released
// ERR   | load failed (err_code says why), core held
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int IMEM_DEPTH     = 1024,
  parameter int ADDR_W         = $clog2(IMEM_DEPTH),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic [ADDR_W:0]   o_words_loaded
);

  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  // Reload value: expiry fires on the TIMEOUT_CYCLES-th consecutive idle cycle.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W:0]  ONE_W    = (ADDR_W + 1)'(1);

  loader_state_t     r_state;
  loader_err_t       r_err_code;
  logic              r_rx_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_core_hold;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_words_loaded;
  logic [ADDR_W:0]   r_len;
  logic [7:0]        r_csum;
  logic [TMO_W-1:0]  r_tmo;

  logic              w_xfer;
  logic              w_start_ok;
  logic              w_push;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_next_count;

  assign w_xfer       = i_rx_valid & r_rx_ready;
  assign w_start_ok   = i_start & ((r_state == IDLE) | (r_state == DONE) | (r_state == ERR));
  assign w_push       = w_xfer & ((r_state == LEN) | (r_state == DATA));
  assign w_next_count = r_words_loaded + ONE_W;

  byte_word_packer u_packer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clr        (w_start_ok),
    .i_push       (w_push),
    .i_byte       (i_rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Loader FSM with checksum, idle timeout and imem write port.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_err_code     <= LDR_ERR_NONE;
      r_rx_ready     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_core_hold    <= 1'b1;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_words_loaded <= '0;
      r_len          <= '0;
      r_csum         <= '0;
      r_tmo          <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        LEN, DATA, CSUM: begin
          if (!w_xfer) begin
            if (r_tmo == '0) begin
              // Any partially packed word is simply abandoned in the packer.
              r_state    <= ERR;
              r_err      <= 1'b1;
              r_err_code <= LDR_ERR_TIMEOUT;
              r_rx_ready <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_tmo <= r_tmo - 1'b1;
            end
          end else begin
            r_tmo <= TMO_LOAD;
            case (r_state)
              LEN: begin
                if (w_word_valid) begin
                  if ((w_word == 32'd0) || (w_word > 32'(IMEM_DEPTH))) begin
                    r_state    <= ERR;
                    r_err      <= 1'b1;
                    r_err_code <= LDR_ERR_LEN;
                    r_rx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                  end else begin
                    r_len   <= w_word[ADDR_W:0];
                    r_state <= DATA;
                  end
                end
              end
              DATA: begin
                r_csum <= r_csum ^ i_rx_data;
                if (w_word_valid) begin
                  r_we           <= 1'b1;
                  r_addr         <= r_words_loaded[ADDR_W-1:0];
                  r_wdata        <= w_word;
                  r_words_loaded <= w_next_count;
                  if (w_next_count == r_len) begin
                    r_state <= CSUM;
                  end
                end
              end
              default: begin
                r_rx_ready <= 1'b0;
                r_busy     <= 1'b0;
                if (i_rx_data == r_csum) begin
                  r_state     <= DONE;
                  r_done      <= 1'b1;
                  r_core_hold <= 1'b0;
                end else begin
                  r_state    <= ERR;
                  r_err      <= 1'b1;
                  r_err_code <= LDR_ERR_CSUM;
                end
              end
            endcase
          end
        end
        default: begin
          if (w_start_ok) begin
            r_state        <= LEN;
            r_rx_ready     <= 1'b1;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_err_code     <= LDR_ERR_NONE;
            r_core_hold    <= 1'b1;
            r_words_loaded <= '0;
            r_csum         <= '0;
            r_tmo          <= TMO_LOAD;
          end
        end
      endcase
    end
  end

  assign o_rx_ready     = r_rx_ready;
  assign o_imem_we      = r_we;
  assign o_imem_addr    = r_addr;
  assign o_imem_wdata   = r_wdata;
  assign o_core_hold    = r_core_hold;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_err_code     = r_err_code;
  assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: byte streams built from a word list, expected
// outcome derived from the load rules (length window, idle limit, XOR checksum).
module tb_imem_boot_loader;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  imem_boot_loader #(.IMEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_rx_valid     (rx_valid),
    .i_rx_data      (rx_data),
    .o_rx_ready     (rx_ready),
    .o_imem_we      (imem_we),
    .o_imem_addr    (imem_addr),
    .o_imem_wdata   (imem_wdata),
    .o_core_hold    (core_hold),
    .o_busy         (busy),
    .o_done         (done),
    .o_err          (err),
    .o_err_code     (err_code),
    .o_words_loaded (words_loaded)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [AW-1:0] wq_addr[$];
  logic [31:0]   wq_data[$];
  logic [31:0]   wbuf[16];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wq_addr.push_back(imem_addr);
      wq_data.push_back(imem_wdata);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    ok = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 40; t++) begin
      if (rx_ready === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic set_case1();
    wbuf[0] = 32'h00500293;
    wbuf[1] = 32'h01400313;
    wbuf[2] = 32'h00628393;
  endtask

  task automatic randomize_words();
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
  endtask

  // Build the stream, predict the outcome from the load rules, drive it, check.
  task automatic run_load(input string name, input logic [31:0] len, input logic [7:0] csum_flip,
                          input int gap_idx, input int gap_len, input bit throttle, input int start_idx);
    logic [7:0] bytes[$];
    int         gaps[$];
    logic [7:0] cs;
    bit         len_ok;
    int         stop;
    int         exp_err;
    int         nexp;
    bit         ok;
    logic [7:0] bv;

    len_ok = (len != 0) && (len <= DEPTH);
    cs = 8'h00;
    for (int i = 0; i < 4; i++) bytes.push_back(len[8*i +: 8]);
    if (len_ok) begin
      for (int w = 0; w < int'(len); w++) begin
        for (int b = 0; b < 4; b++) begin
          bv = wbuf[w][8*b +: 8];
          bytes.push_back(bv);
          cs ^= bv;
        end
      end
      bytes.push_back(cs ^ csum_flip);
    end
    for (int i = 0; i < bytes.size(); i++) begin
      gaps.push_back(throttle ? int'($urandom_range(0, 3)) : 0);
      if (i == gap_idx) gaps[i] = gap_len;
    end

    stop = bytes.size();
    exp_err = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      if (gaps[i] >= TMO) begin
        stop = i;
        exp_err = 3;
        break;
      end
    end
    if (exp_err == 0) begin
      if (!len_ok) exp_err = 1;
      else if (csum_flip != 8'h00) exp_err = 2;
    end
    nexp = 0;
    if (len_ok)
      for (int k = 0; k < int'(len); k++)
        if (4 + 4*k + 3 < stop) nexp++;

    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    for (int i = 0; i < stop; i++) begin
      if (i == start_idx) pulse_start();
      send_byte(bytes[i], gaps[i], ok);
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s byte_accept: byte %0d not accepted within bound, required accept", name, i);
        break;
      end
    end
    if (stop < bytes.size()) repeat (gaps[stop] + 4) @(negedge clk);
    else repeat (4) @(negedge clk);

    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b want 0", name, busy); end
    n_checks++;
    if (done !== (exp_err == 0)) begin n_fail++; $display("FAIL %s done: got %b want %0d", name, done, exp_err == 0); end
    n_checks++;
    if (err !== (exp_err != 0)) begin n_fail++; $display("FAIL %s err: got %b want %0d", name, err, exp_err != 0); end
    n_checks++;
    if (err_code !== 2'(exp_err)) begin n_fail++; $display("FAIL %s err_code: got %0d want %0d", name, err_code, exp_err); end
    n_checks++;
    if (core_hold !== (exp_err != 0)) begin n_fail++; $display("FAIL %s core_hold: got %b want %0d", name, core_hold, exp_err != 0); end
    n_checks++;
    if (words_loaded !== (AW+1)'(nexp)) begin n_fail++; $display("FAIL %s words_loaded: got %0d want %0d", name, words_loaded, nexp); end
    n_checks++;
    if (wq_addr.size() != nexp) begin n_fail++; $display("FAIL %s write_count: got %0d want %0d", name, wq_addr.size(), nexp); end
    for (int k = 0; k < nexp && k < wq_addr.size(); k++) begin
      n_checks++;
      if (wq_addr[k] !== AW'(k) || wq_data[k] !== wbuf[k]) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got addr %0d data %h want addr %0d data %h", name, k, wq_addr[k], wq_data[k], k, wbuf[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rx_ready, imem_we, busy, done, err, err_code, words_loaded} !== '0 || core_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b we=%b busy=%b done=%b err=%b code=%0d wl=%0d hold=%b want all 0, hold=1",
               rx_ready, imem_we, busy, done, err, err_code, words_loaded, core_hold);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_case1();
    run_load("case1", 32'd3, 8'h00, -1, 0, 1'b0, -1);
  endtask

  task automatic test_bad_len();
    randomize_words();
    run_load("len0", 32'd0, 8'h00, -1, 0, 1'b0, -1);
    run_load("len9", 32'd9, 8'h00, -1, 0, 1'b0, -1);
    run_load("len_huge", 32'h0100_0003, 8'h00, -1, 0, 1'b0, -1);
    run_load("len8", 32'd8, 8'h00, -1, 0, 1'b0, -1);
  endtask

  task automatic test_csum_err();
    set_case1();
    run_load("csum_bad", 32'd3, 8'h01, -1, 0, 1'b0, -1);
  endtask

  task automatic test_timeout();
    set_case1();
    run_load("gap15", 32'd3, 8'h00, 10, TMO - 1, 1'b0, -1);
    run_load("gap16", 32'd3, 8'h00, 10, TMO, 1'b0, -1);
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    logic [7:0] bv;
    set_case1();
    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      bv = (i == 0) ? 8'd3 : 8'd0;
      send_byte(bv, 0, ok);
    end
    for (int i = 0; i < 8; i++) begin
      bv = wbuf[i/4][8*(i%4) +: 8];
      send_byte(bv, 0, ok);
    end
    for (int t = 0; t < 10 && wq_addr.size() < 2; t++) @(negedge clk);
    n_checks++;
    if (wq_addr.size() != 2) begin n_fail++; $display("FAIL rst_mid writes_before: got %0d want 2", wq_addr.size()); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || core_hold !== 1'b1 || words_loaded !== '0 || rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid state: got busy=%b hold=%b wl=%0d rdy=%b want 0 1 0 0", busy, core_hold, words_loaded, rx_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_load("after_reset", 32'd3, 8'h00, -1, 0, 1'b0, -1);
  endtask

  task automatic test_start_handling();
    set_case1();
    run_load("start_in_data", 32'd3, 8'h00, -1, 0, 1'b0, 6);
    pulse_start();
    n_checks++;
    if (core_hold !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_done: got hold=%b busy=%b done=%b rdy=%b want 1 1 0 1", core_hold, busy, done, rx_ready);
    end
  endtask

  task automatic test_throttle();
    set_case1();
    run_load("throttle_case1", 32'd3, 8'h00, -1, 0, 1'b1, -1);
    for (int r = 0; r < 3; r++) begin
      randomize_words();
      run_load("throttle_rand", 32'($urandom_range(1, DEPTH)), 8'h00, -1, 0, 1'b1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_len();
    test_csum_err();
    test_timeout();
    test_reset_mid_load();
    test_start_handling();
    test_throttle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
